flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Sits directly downstream of the EX-stage saturating add/sub and ALU result mux.
- Captures the Z/V/N condition flags from each flag-setting instruction retiring from EX.
- Evaluates the 3-bit branch condition for the B/BR instruction in ID and produces br_taken.
- Owns the HALTED freeze state entered on HLT.

Parameters:
- WIDTH, 16, ALU result width; N is taken from bit WIDTH-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  instruction in EX is valid
- ex_opcode  in  4  opcode of the EX instruction
- alu_out  in  WIDTH  final, post-saturation ALU result
- alu_ovfl  in  1  overflow from add/sub, meaningful only for ADD/SUB
- stall  in  1  pipeline stall; holds all state
- flush  in  1  squashes the EX instruction this cycle
- br_eval  in  1  branch (B/BR) present in ID
- br_cond  in  3  condition field of that branch
- flags  out  3  registered {Z,V,N}
- br_taken  out  1  condition satisfied (combinational)
- flag_hazard  out  1  ID branch must stall one cycle
- halted  out  1  HLT has retired

Behaviour:
- Reset: flags=3'b000, halted=0, state=RUN.
  - flag_hazard=0 during reset.
  - br_taken follows the condition rule using flags=000.
- Update enable: upd = ex_valid & ~stall & ~flush & (state==RUN).
- Flag writes on the clock edge when upd is high:
  - ADD (0000) and SUB (0001) write Z, V and N.
    - Z = (alu_out==0).
    - V = alu_ovfl.
    - N = alu_out[WIDTH-1].
  - XOR (0010), SLL (0100), SRA (0101) and ROR (0110) write Z only; V and N hold.
  - All other opcodes leave flags unchanged.
- Z is computed on the saturated result. A saturated sum 0x7FFF or 0x8000 gives Z=0 with V=1.
- Conditions on effective flags (eff):
  - 000: ~Z
  - 001: Z
  - 010: ~Z & ~N
  - 011: N
  - 100: Z | (~Z & ~N)
  - 101: N | Z
  - 110: V
  - 111: always taken
- br_taken = br_eval & cond(eff). It is 0 when br_eval=0.
- Latency:
  - Flags become visible on `flags` one cycle after the EX instruction.
  - br_taken is same-cycle combinational from eff.
- State machine:
  - RUN -> HALTED when upd and ex_opcode==1111.
  - HALTED is absorbing until rst.
  - In HALTED, flags freeze and halted=1.
- Simultaneous events:
  - stall together with flush: stall wins, nothing changes.
  - flush together with HLT in EX: no transition.
- rst asserted in any cycle overrides all other inputs at the next edge.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - eff = next-state flags: the value that would be written if upd and the opcode sets flags, else the registered flags.
  - flag_hazard is tied 0.
- Undefined:
  - eff = registered flags.
  - flag_hazard = br_eval & upd & (ex_opcode sets any flag) & (br_cond != 111).
  - ID stalls on flag_hazard. br_taken is still driven from stale flags and must be ignored by the fetch logic while flag_hazard=1.

Decomposition:
- Package wisc_pkg holds:
  - opcode_t enum (4-bit WISC opcodes).
  - cond_t enum (NE, EQ, GT, LT, GTE, LTE, OV, UNCOND).
  - flags_t packed struct {z,v,n}.
  - Helper functions sets_all_flags(opcode_t) and sets_z_only(opcode_t).
- One combinational sub-module, branch_cond_eval:
  - Inputs: flags_t, cond_t.
  - Output: taken.
  - It is reused by the BR target logic.

Test Plan:
- Reset then br_eval=1, cond=001 -> br_taken=0. With cond=111 -> br_taken=1. flags=000.
- ADD with alu_out=0x7FFF, alu_ovfl=1 (saturated) -> next cycle flags Z=0,V=1,N=0. Branch cond=110 -> br_taken=1.
- SUB result 0x0000, then XOR result 0x8000 -> after the XOR, Z=0 and V/N still 0 from the SUB. cond=000 -> taken=1.
- ADD result 0xFFF0 with flush=1 -> flags unchanged. Same instruction with stall=1 -> unchanged. With both low -> N=1,Z=0.
- HLT in EX, then ADD result 0 -> halted=1 from the next cycle and Z stays 0. Assert rst -> halted=0.
- Back-to-back SUB result 0 in EX with branch cond=001 in ID:
  - With FLAG_BYPASS_EN: br_taken=1, flag_hazard=0.
  - Without it: flag_hazard=1. The next cycle gives br_taken=1 from the registered Z.

Source files
------------

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared WISC opcode/condition encodings, flag struct and flag-setting helpers
package wisc_pkg;
  typedef enum logic [3:0] {
    ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB,
    LW, SW, LLB, LHB, B, BR, PCS, HLT
  } opcode_t;
  typedef enum logic [2:0] {NE, EQ, GT, LT, GTE, LTE, OV, UNCOND} cond_t;
  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;
  function automatic logic sets_all_flags(opcode_t op);
    return op inside {ADD, SUB};
  endfunction
  function automatic logic sets_z_only(opcode_t op);
    return op inside {XOR, SLL, SRA, ROR};
  endfunction
endpackage

// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if: EX result, ID branch request and flag/branch status bundle
interface flag_branch_unit_if import wisc_pkg::*; #(parameter int WIDTH = 16);
  logic             ex_valid;
  logic [3:0]       ex_opcode;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovfl;
  logic             stall;
  logic             flush;
  logic             br_eval;
  logic [2:0]       br_cond;
  flags_t           flags;
  logic             br_taken;
  logic             flag_hazard;
  logic             halted;
  modport master (
    output ex_valid, ex_opcode, alu_out, alu_ovfl, stall, flush, br_eval, br_cond,
    input  flags, br_taken, flag_hazard, halted
  );
  modport slave (
    input  ex_valid, ex_opcode, alu_out, alu_ovfl, stall, flush, br_eval, br_cond,
    output flags, br_taken, flag_hazard, halted
  );
endinterface

// File: rtl/flag_branch_unit_branch_cond_eval.sv
// branch_cond_eval: decides whether a 3-bit branch condition holds for a given flag set
module branch_cond_eval import wisc_pkg::*; (
  input  flags_t f,
  input  cond_t  cond,
  output logic   taken
);
  always_comb begin
    taken = 1'b0;
    case (cond)
      NE:     taken = ~f.z;
      EQ:     taken = f.z;
      GT:     taken = ~f.z & ~f.n;
      LT:     taken = f.n;
      GTE:    taken = f.z | (~f.z & ~f.n);
      LTE:    taken = f.n | f.z;
      OV:     taken = f.v;
      UNCOND: taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: Z/V/N flag register, ID branch resolution and HLT freeze.
// FLAG_BYPASS_EN forwards the EX instruction's flags to the ID branch instead of stalling it.
module flag_branch_unit import wisc_pkg::*; #(parameter int WIDTH = 16) (
  input logic               clk,
  input logic               rst,
  flag_branch_unit_if.slave bus
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t  state_q, state_d;
  flags_t  flags_q, flags_d, eff;
  opcode_t op;
  logic    upd, sets_any, zero, taken;
  always_comb begin
    op = opcode_t'(bus.ex_opcode);
    upd = bus.ex_valid & ~bus.stall & ~bus.flush & (state_q == RUN);
    sets_any = sets_all_flags(op) | sets_z_only(op);
    zero = bus.alu_out == '0;
    flags_d = !upd ? flags_q :
              sets_all_flags(op) ? flags_t'{z: zero, v: bus.alu_ovfl, n: bus.alu_out[WIDTH-1]} :
              sets_z_only(op) ? flags_t'{z: zero, v: flags_q.v, n: flags_q.n} : flags_q;
    state_d = (upd && op == HLT) ? HALTED : state_q;
`ifdef FLAG_BYPASS_EN
    eff = rst ? '0 : flags_d;
    bus.flag_hazard = 1'b0;
`else
    eff = rst ? '0 : flags_q;
    bus.flag_hazard = ~rst & bus.br_eval & upd & sets_any & (bus.br_cond != 3'b111);
`endif
    bus.br_taken = bus.br_eval & taken;
    bus.flags = flags_q;
    bus.halted = state_q == HALTED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      state_q <= RUN;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end
  branch_cond_eval u_cond (
    .f     (eff),
    .cond  (cond_t'(bus.br_cond)),
    .taken (taken)
  );
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed and randomized checks against a flag/halt reference model
module tb_flag_branch_unit;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  flag_branch_unit_if #(.WIDTH(W)) bus ();
  flag_branch_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic m_z = 1'b0, m_v = 1'b0, m_n = 1'b0, m_h = 1'b0;

  function automatic logic m_upd();
    return bus.ex_valid & ~bus.stall & ~bus.flush & ~m_h;
  endfunction

  function automatic logic sets_flags();
    return bus.ex_opcode inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
  endfunction

  // model's view of {Z,V,N} after this cycle's EX instruction retires
  function automatic logic [2:0] nxt_flags();
    logic z;
    z = bus.alu_out == 0;
    if (m_upd() && bus.ex_opcode <= 4'd1) return {z, bus.alu_ovfl, bus.alu_out[W-1]};
    if (m_upd() && sets_flags()) return {z, m_v, m_n};
    return {m_z, m_v, m_n};
  endfunction

  function automatic logic exp_taken();
    logic [2:0] e;
    logic [7:0] t;
`ifdef FLAG_BYPASS_EN
    e = nxt_flags();
`else
    e = {m_z, m_v, m_n};
`endif
    if (rst) e = 3'b000;
    t = {1'b1, e[1], e[0] | e[2], e[2] | ~e[0], e[0], ~e[2] & ~e[0], e[2], ~e[2]};
    return bus.br_eval & t[bus.br_cond];
  endfunction

  function automatic logic exp_hazard();
`ifdef FLAG_BYPASS_EN
    return 1'b0;
`else
    return ~rst & bus.br_eval & m_upd() & sets_flags() & (bus.br_cond != 3'd7);
`endif
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] alu,
                       input logic ov, input logic st, input logic fl,
                       input logic be, input logic [2:0] bc);
    bus.ex_valid = v; bus.ex_opcode = op; bus.alu_out = alu; bus.alu_ovfl = ov;
    bus.stall = st; bus.flush = fl; bus.br_eval = be; bus.br_cond = bc;
    #1;
  endtask

  task automatic tick();
    logic [2:0] nf;
    nf = nxt_flags();
    if (rst) begin
      {m_z, m_v, m_n} = 3'b000;
      m_h = 1'b0;
    end else begin
      if (m_upd() && bus.ex_opcode == 4'hF) m_h = 1'b1;
      {m_z, m_v, m_n} = nf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    n_chk++;
    if (bus.flag_hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", bus.flag_hazard); end
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    n_chk++;
    if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", bus.flags); end
    n_chk++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    n_chk++;
    if (bus.br_taken !== 1'b0) begin n_fail++; $display("FAIL reset_eq got %b want 0", bus.br_taken); end
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
    n_chk++;
    if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL reset_uncond got %b want 1", bus.br_taken); end
  endtask

  task automatic test_saturate();
    drive(1'b1, 4'd0, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    n_chk++;
    if (bus.flags !== 3'b010) begin n_fail++; $display("FAIL sat_flags got %b want 010", bus.flags); end
    n_chk++;
    if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL sat_ov got %b want 1", bus.br_taken); end
  endtask

  task automatic test_z_only();
    drive(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    drive(1'b1, 4'd2, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    n_chk++;
    if (bus.flags !== 3'b100) begin n_fail++; $display("FAIL sub_zero_flags got %b want 100", bus.flags); end
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    n_chk++;
    if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL xor_flags got %b want 000", bus.flags); end
    n_chk++;
    if (bus.br_taken !== 1'b1) begin n_fail++; $display("FAIL xor_ne got %b want 1", bus.br_taken); end
  endtask

  task automatic test_flush_stall();
    logic [1:0] sf [3] = '{2'b01, 2'b10, 2'b11};
    foreach (sf[i]) begin
      drive(1'b1, 4'd0, 16'hFFF0, 1'b0, sf[i][1], sf[i][0], 1'b0, 3'd0);
      tick();
      n_chk++;
      if (bus.flags !== 3'b000) begin n_fail++; $display("FAIL hold_%0d_flags got %b want 000", i, bus.flags); end
    end
    drive(1'b1, 4'd0, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    n_chk++;
    if (bus.flags !== 3'b001) begin n_fail++; $display("FAIL add_neg_flags got %b want 001", bus.flags); end
  endtask

  task automatic test_halt();
    drive(1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    tick();
    n_chk++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL flushed_hlt got %b want 0", bus.halted); end
    drive(1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    n_chk++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL hlt_halted got %b want 1", bus.halted); end
    drive(1'b1, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    n_chk++;
    if (bus.flags !== 3'b001) begin n_fail++; $display("FAIL frozen_flags got %b want 001", bus.flags); end
    n_chk++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL still_halted got %b want 1", bus.halted); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    n_chk++;
    if (bus.halted !== 1'b0 || bus.flags !== 3'b000) begin
      n_fail++; $display("FAIL rst_unhalt got halted=%b flags=%b want 0/000", bus.halted, bus.flags);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
`ifdef FLAG_BYPASS_EN
    n_chk++;
    if (bus.br_taken !== 1'b1 || bus.flag_hazard !== 1'b0) begin
      n_fail++; $display("FAIL b2b_bypass got taken=%b hazard=%b want 1/0", bus.br_taken, bus.flag_hazard);
    end
`else
    n_chk++;
    if (bus.flag_hazard !== 1'b1) begin n_fail++; $display("FAIL b2b_hazard got %b want 1", bus.flag_hazard); end
`endif
    bus.br_cond = 3'd7;
    #1;
    n_chk++;
    if (bus.flag_hazard !== 1'b0 || bus.br_taken !== 1'b1) begin
      n_fail++; $display("FAIL b2b_uncond got hazard=%b taken=%b want 0/1", bus.flag_hazard, bus.br_taken);
    end
    bus.br_cond = 3'd1;
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    n_chk++;
    if (bus.br_taken !== 1'b1 || bus.flag_hazard !== 1'b0) begin
      n_fail++; $display("FAIL b2b_next got taken=%b hazard=%b want 1/0", bus.br_taken, bus.flag_hazard);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] vals [5];
    logic et, eh;
    for (int i = 0; i < 400; i++) begin
      vals = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, W'($urandom)};
      rst = ($urandom_range(0, 29) == 0);
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), vals[$urandom_range(0, 4)],
            1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
            1'($urandom), 3'($urandom));
      et = exp_taken();
      eh = exp_hazard();
      n_chk++;
      if (bus.br_taken !== et || bus.flag_hazard !== eh) begin
        n_fail++; $display("FAIL rnd_%0d_branch got taken=%b hazard=%b want %b/%b", i, bus.br_taken, bus.flag_hazard, et, eh);
      end
      tick();
      n_chk++;
      if (bus.flags !== {m_z, m_v, m_n} || bus.halted !== m_h) begin
        n_fail++; $display("FAIL rnd_%0d_state got flags=%b halted=%b want %b/%b", i, bus.flags, bus.halted, {m_z, m_v, m_n}, m_h);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_z_only();
    test_flush_stall();
    test_halt();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
